median_frame_sequencer: RTL
===========================

Name: median_frame_sequencer

Overview:
- Driver for the median filter's pixel-stream interface.
- Fetches a raster frame from a source pixel RAM and streams it into the filter with the load enable asserted.
- Then asserts the process enable and captures the filter's output stream into a destination pixel RAM.
- Sits between the frame buffers and the filter core, replacing bench-driven loading and dumping.

Parameters:
WIDTH, 410, pixels per row
DEPTH, 361, rows per frame
DATA_W, 8, pixel width in bits
ADDR_W, 18, RAM address width; must satisfy 2^ADDR_W >= WIDTH*DEPTH
PROC_LAT, 1, cycles from process_en rising to the first valid filt_pix sample

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins a frame
src_addr  out  ADDR_W  source RAM read address
src_data  in  DATA_W  source RAM read data; valid 1 cycle after src_addr
pix_out  out  DATA_W  pixel to filter image input
load_en  out  1  filter load enable
process_en  out  1  filter process enable
filt_pix  in  DATA_W  filter image output
filt_finish  in  1  filter finish flag
dst_we  out  1  destination RAM write enable
dst_addr  out  ADDR_W  destination write address
dst_data  out  DATA_W  destination write data
busy  out  1  high from the start-accept cycle until done
done  out  1  one-cycle completion pulse
err  out  1  sticky; filt_finish seen before the frame is fully captured

Behaviour:
- N = WIDTH*DEPTH. All outputs are registered.
- Reset: all outputs are 0, FSM is in IDLE, counters are 0. Reset asserted in any state aborts the frame immediately; no further writes occur.
- FSM states: IDLE, LOAD, GAP, CAPTURE, DONE.
- IDLE:
  - start=1 moves to LOAD, sets busy, clears err, zeroes the counters.
  - start while busy is ignored.
- LOAD:
  - src_addr steps 0..N-1, one address per cycle.
  - Each cycle k+1, pix_out = src_data for address k and load_en=1.
  - load_en is high for exactly N consecutive cycles. The first high cycle is the cycle after src_addr=0 is presented.
  - After the cycle carrying pixel N-1, go to GAP.
- GAP:
  - load_en=0 and process_en=1.
  - Count PROC_LAT cycles, then go to CAPTURE. With PROC_LAT=0, go straight to CAPTURE in the same cycle process_en first rises.
  - process_en stays high through CAPTURE.
- CAPTURE:
  - Each cycle, register filt_pix to dst_data with dst_we=1 and dst_addr = sample index 0..N-1.
  - Exactly N writes; addresses are contiguous and never wrap.
  - After write N-1, go to DONE.
  - If filt_finish=1 while fewer than N samples have been written, set err. Capture still completes all N writes.
- DONE:
  - process_en=0, done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
  - A start in the DONE cycle is ignored.
- Address counters saturate at N-1. No arithmetic overflow is possible given the ADDR_W constraint.
- Total latency from start accept to done = 1 + N (load) + PROC_LAT + N (capture) + 1 cycles, ±1 cycle for the RAM read register. The bench checks the exact count 2N+PROC_LAT+3.

Test Plan:
- Small frame, WIDTH=4, DEPTH=3, source RAM = 0..11, filter model echoes load data with PROC_LAT=1 -> load_en high exactly 12 cycles, pix_out = 0,1,...,11; dst RAM = 0..11; done pulse 27 cycles after start; err=0.
- start held high for 5 cycles, then again mid-CAPTURE -> exactly one frame processed; dst_we asserts 12 times total.
- rst asserted in the 6th LOAD cycle -> all outputs 0 asynchronously; next start re-begins at src_addr=0 with no stale dst writes.
- Filter model raises filt_finish after the 8th captured sample -> err=1 at DONE; still 12 writes; err clears on the next start.
- PROC_LAT=0 and PROC_LAT=3 builds -> first dst_we occurs 0 and 3 cycles after process_en rises, respectively; dst contents match the model.
- Full size 410x361 with values (i mod 256) -> 148010 writes; dst_addr ends at 148009; done pulses exactly once.

Source files
------------

// File: rtl/median_frame_sequencer.sv
// median_frame_sequencer
//   Drives the median filter's pixel-stream interface. A frame is read from a
//   source pixel RAM and streamed into the filter with load_en asserted, then
//   process_en is raised and the filter output stream is written into a
//   destination pixel RAM. Total start-to-done span is 2N+PROC_LAT+3 cycles,
//   counting both the start-accept cycle and the done cycle.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start              one-cycle pulse, begins a frame when idle
//   src_addr/src_data  source RAM read port (data one cycle after address)
//   pix_out, load_en   pixel stream into the filter
//   process_en         filter process enable
//   filt_pix           filter output pixel
//   filt_finish        filter finish flag
//   dst_we/addr/data   destination RAM write port
//   busy, done, err    status: busy, done pulse, sticky early-finish error
module median_frame_sequencer #(
    parameter int WIDTH    = 410,
    parameter int DEPTH    = 361,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 18,
    parameter int PROC_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    output logic [DATA_W-1:0] pix_out,
    output logic              load_en,
    output logic              process_en,
    input  logic [DATA_W-1:0] filt_pix,
    input  logic              filt_finish,
    output logic              dst_we,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [DATA_W-1:0] dst_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int N  = WIDTH * DEPTH;
    localparam int GW = $clog2(PROC_LAT + 2);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(N - 1);
    localparam logic [GW-1:0]     GAP_END = GW'(PROC_LAT);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] src_addr_q, src_addr_d;
    logic [ADDR_W-1:0] ld_cnt_q, ld_cnt_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0] pix_q, pix_d;
    logic              load_en_q, load_en_d;
    logic              proc_q, proc_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              capture, last_wr;

    function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
        return (v == LAST) ? v : v + ADDR_W'(1);
    endfunction

    // With PROC_LAT=0 the first capture happens on the same edge that
    // raises process_en, so GAP doubles as the first capture cycle.
    assign capture = ((state_q == S_GAP) && (gap_cnt_q == GAP_END)) || (state_q == S_CAP);
    assign last_wr = capture && (wr_cnt_q == LAST);

    always_comb begin
        state_d    = state_q;
        src_addr_d = src_addr_q;
        ld_cnt_d   = ld_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        pix_d      = pix_q;
        load_en_d  = 1'b0;
        proc_d     = proc_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;

        if (capture) begin
            we_d     = 1'b1;
            wdata_d  = filt_pix;
            waddr_d  = wr_cnt_q;
            wr_cnt_d = sat_inc(wr_cnt_q);
        end
        // A finish flag on the edge that captures the final sample is the
        // normal end of stream; anything earlier means samples were lost.
        if ((state_q == S_GAP || state_q == S_CAP) && filt_finish && !last_wr)
            err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                proc_d = 1'b0;
                // busy_q is still high in the done cycle, which masks start there
                if (start && !busy_q) begin
                    state_d    = S_LOAD;
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                    ld_cnt_d   = '0;
                    wr_cnt_d   = '0;
                    gap_cnt_d  = '0;
                    // address 0 is already on the bus while idle, so the
                    // read pipeline is primed by the time LOAD starts
                    src_addr_d = sat_inc('0);
                end
            end
            S_LOAD: begin
                pix_d      = src_data;
                load_en_d  = 1'b1;
                src_addr_d = sat_inc(src_addr_q);
                if (ld_cnt_q == LAST) state_d = S_GAP;
                else                  ld_cnt_d = ld_cnt_q + ADDR_W'(1);
            end
            S_GAP: begin
                proc_d = 1'b1;
                if (gap_cnt_q == GAP_END) state_d = last_wr ? S_DONE : S_CAP;
                else                      gap_cnt_d = gap_cnt_q + GW'(1);
            end
            S_CAP: begin
                if (last_wr) state_d = S_DONE;
            end
            S_DONE: begin
                proc_d     = 1'b0;
                done_d     = 1'b1;
                src_addr_d = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            src_addr_q <= '0;
            ld_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            gap_cnt_q  <= '0;
            pix_q      <= '0;
            load_en_q  <= 1'b0;
            proc_q     <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_addr_q <= src_addr_d;
            ld_cnt_q   <= ld_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            pix_q      <= pix_d;
            load_en_q  <= load_en_d;
            proc_q     <= proc_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign src_addr   = src_addr_q;
    assign pix_out    = pix_q;
    assign load_en    = load_en_q;
    assign process_en = proc_q;
    assign dst_we     = we_q;
    assign dst_addr   = waddr_q;
    assign dst_data   = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
endmodule
